// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, shifter mode codes and arbiter state encoding.
// Revision: 1.0
`default_nettype none

package shift_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRA = 2'b01;
  localparam logic [1:0] SHIFT_ROR = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
endpackage

`default_nettype wire

// File: rtl/shift_arbiter_shifter.sv
// shift_arbiter_shifter: combinational 16-bit SLL / SRA / ROR (mode 11 also rotates).
// Revision: 1.0
`default_nettype none

module shift_arbiter_shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [AMT_W-1:0]  i_amt,
  input  logic [1:0]        i_mode,
  output logic [DATA_W-1:0] o_data
);

  logic [AMT_W:0] w_rot_left;

  // Left half of the rotate; amt=0 gives a 16-bit shift, which contributes zero.
  assign w_rot_left = 5'd16 - {1'b0, i_amt};

  always_comb begin
    o_data = i_data;
    case (i_mode)
      SHIFT_SLL: o_data = i_data << i_amt;
      SHIFT_SRA: o_data = $signed(i_data) >>> i_amt;
      default:   o_data = (i_data >> i_amt) | (i_data << w_rot_left);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester valid/ready front end for one shared 16-bit shifter.
// Define SHIFT_ARB_RR_EN for round-robin on ties; default is fixed priority to requester 0.
`default_nettype none

module shift_arbiter
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic [1:0]        req0_mode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  input  logic [1:0]        req1_mode,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_owner;
  logic              r_last_grant;
  logic [DATA_W-1:0] r_data;
  logic [AMT_W-1:0]  r_amt;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_rsp_data;
  logic [DATA_W-1:0] w_shift;
  logic              w_any;
  logic              w_pick1;
  logic              w_rsp_hs;
  logic              w_accept;

  assign w_any    = req0_valid | req1_valid;
  assign w_rsp_hs = (r_state == ST_RESP) & (r_owner ? rsp1_ready : rsp0_ready);
  assign w_accept = w_any & ((r_state == ST_IDLE) | w_rsp_hs);

`ifdef SHIFT_ARB_RR_EN
  assign w_pick1 = req1_valid & (~req0_valid | ~r_last_grant);
`else
  // last_grant is kept up to date but never changes the fixed-priority outcome.
  assign w_pick1 = req1_valid & (~req0_valid | (r_last_grant & 1'b0));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: if (w_rsp_hs) w_next_state = w_any ? ST_EXEC : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_accept & ~w_pick1;
    req1_ready = w_accept & w_pick1;
    rsp0_valid = (r_state == ST_RESP) & ~r_owner;
    rsp1_valid = (r_state == ST_RESP) & r_owner;
    busy       = (r_state != ST_IDLE);
  end

  // Only the granted port's operand fields are captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_data       <= '0;
      r_amt        <= '0;
      r_mode       <= SHIFT_SLL;
      r_rsp_data   <= '0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_pick1;
        r_last_grant <= w_pick1;
        r_data       <= w_pick1 ? req1_data : req0_data;
        r_amt        <= w_pick1 ? req1_amt  : req0_amt;
        r_mode       <= w_pick1 ? req1_mode : req0_mode;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= w_shift;
      end
    end
  end

  shift_arbiter_shifter u_shifter (
    .i_data (r_data),
    .i_amt  (r_amt),
    .i_mode (r_mode),
    .o_data (w_shift)
  );

  assign rsp_data = r_rsp_data;

endmodule

`default_nettype wire

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 16-bit shifter (modes SLL/SRA/ROR) between two requesters using valid/ready handshakes on request and response. Latches the winning operands, performs the shift in a dedicated cycle, and holds a registered result until the owning requester accepts it. Sits beside the execute stage: requester 0 is the ALU shift path, requester 1 is the secondary datapath client (e.g. byte/halfword alignment).

## Interface
- DATA_W, 16, operand/result width; fixed at 16 to match the shifter.
- AMT_W, 4, shift-amount width; fixed at 4.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_data / req1_data  input  16  operand.
- req0_amt / req1_amt  input  4  shift amount, 0..15.
- req0_mode / req1_mode  input  2  00=SLL, 01=SRA, 10/11=ROR.
- rsp0_valid / rsp1_valid  output  1  result available for that requester.
- rsp0_ready / rsp1_ready  input  1  requester takes result.
- rsp_data  output  16  shared result bus, valid only with rspN_valid.
- busy  output  1  high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one. Assert reqN_ready for the winner only (combinational), latch data/amt/mode plus owner ID, then go to EXEC.
- EXEC: latched operands drive the shifter. The result is registered into rsp_data, then go to RESP.
- RESP: assert rsp{owner}_valid. Hold rsp_data stable until rsp{owner}_ready.
  - On the handshake, if any reqN_valid in the same cycle, arbitrate, accept (reqN_ready=1), latch, and go to EXEC (back-to-back).
  - Otherwise go to IDLE.
- Only the owner's rsp_ready is sampled. The other rsp_ready is ignored.
- Arbitration when both valid: see Configuration. A single valid requester always wins.
- Shift semantics:
  - SLL zero-fills.
  - SRA replicates bit 15.
  - ROR rotates right.
  - amt=0 passes the operand unchanged in all modes.
- Owner register records the granted requester. last_grant updates on every accepted request.
- A requester may drop valid without being granted; nothing is latched.
- Data on a non-granted request port is never sampled.

## Timing
- Request accepted at cycle T (reqN_valid & reqN_ready) gives rspN_valid high from T+2.
- Minimum throughput: one operation per 2 cycles, via back-to-back from RESP. From IDLE the spacing is 3 cycles.
- reqN_ready is never high in EXEC. It is high in RESP only in the cycle the owner's response handshake completes.
- At most one reqN_ready and at most one rspN_valid high in any cycle.
- Reset (rst_n low at a clock edge), from any state including mid-operation:
  - state = IDLE, busy = 0.
  - all reqN_ready and rspN_valid = 0, rsp_data = 16'h0000.
  - owner = 0, last_grant = 1, so requester 0 wins the first tie.
  - Any in-flight operation is discarded with no response.

## Configuration
- SHIFT_ARB_RR_EN defined: round-robin on tie. The requester not equal to last_grant wins.
- SHIFT_ARB_RR_EN undefined: fixed priority. Requester 0 always wins a tie. last_grant is still maintained but unused.

## Structure
- Shared package shift_pkg holds:
  - mode constants SHIFT_SLL=2'b00, SHIFT_SRA=2'b01, SHIFT_ROR=2'b10.
  - state encoding IDLE/EXEC/RESP.
  - DATA_W/AMT_W constants.
- One sub-module: the existing 16-bit Shifter, instantiated once and fed from the latched operand registers. The arbiter contains no shift logic itself.

## Test plan
- Req0 alone, data 16'h0001, amt 4, mode SLL at T -> req0_ready at T, rsp0_valid at T+2, rsp_data 16'h0010; rsp1_valid stays 0.
- Req1 alone, data 16'h8000, amt 3, mode SRA -> rsp_data 16'hF000. Then 16'h0001, amt 1, mode ROR -> rsp_data 16'h8000. Then amt 0, any mode, data 16'hA5A5 -> rsp_data 16'hA5A5.
- Both valid continuously, rsp ready always 1:
  - RR_EN defined: grants alternate 0,1,0,1.
  - RR_EN undefined: grants 0,0,0 and req1 is starved.
- Backpressure: rsp0_ready low for 5 cycles -> rsp0_valid and rsp_data stable, busy=1, no reqN_ready. On release with req1 pending -> req1_ready in the same cycle, rsp1_valid 2 cycles later.
- Stray ready: rsp1_ready high while owner=0 and rsp0_ready low -> no state change, result held.
- Reset mid-operation: rst_n low during EXEC -> next cycle all outputs 0 and IDLE. After release, a simultaneous req0+req1 grants req0 first.
